// File: rtl/spi_slave.sv
// spi_slave: SPI serial front end for the SPI RAM; deserialises MOSI frames
//   into RAM command words and serialises RAM read bytes back onto MISO.
// Latency: rx_valid registered on the edge that samples the last frame bit;
//   MISO carries the read MSB from the edge that samples tx_valid high.
// Backpressure: none; SS_n high aborts or ends a transaction at any point.
//
// Ports:
//   clk       system clock, all logic on the rising edge
//   rst_n     synchronous active-low reset
//   SS_n      slave select (active-low), MOSI serial in (MSB first)
//   MISO      serial out (MSB first), 0 whenever not transmitting
//   rx_data   {opcode[1:0], addr/data[ADDR_SIZE-1:0]} frame to the RAM
//   rx_valid  one-cycle strobe qualifying rx_data
//   tx_data   read byte from the RAM, tx_valid qualifies it
//
// Build option: define SPI_IN_SYNC_EN to put SS_n and MOSI through 2-flop
// synchronisers (all input-referenced timing moves two cycles later).

module spi_slave #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);

  localparam int FW    = ADDR_SIZE + 2;          // frame width
  localparam int CNT_W = $clog2(FW);             // frame bit counter
  localparam int TXC_W = $clog2(ADDR_SIZE + 1);  // counts 0..ADDR_SIZE

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_e;

  // Sub-phases used once a READ_DATA frame has been received.
  typedef enum logic [1:0] {
    RD_HOLD,   // rx_valid cycle: tx_valid may still show a stale level
    RD_WAIT,   // sample tx_valid
    RD_SHIFT,  // byte going out on MISO
    RD_DONE    // byte finished, ignore everything until SS_n rises
  } rd_phase_e;

  // --------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------
  logic ss_n_s;
  logic mosi_s;

`ifdef SPI_IN_SYNC_EN
  logic ss_meta_q,   ss_meta_d;
  logic ss_sync_q,   ss_sync_d;
  logic mosi_meta_q, mosi_meta_d;
  logic mosi_sync_q, mosi_sync_d;

  always_comb begin
    ss_meta_d   = SS_n;
    ss_sync_d   = ss_meta_q;
    mosi_meta_d = MOSI;
    mosi_sync_d = mosi_meta_q;
  end

  // Reset to "deselected" so the FSM never sees a phantom start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ss_meta_q   <= 1'b1;
      ss_sync_q   <= 1'b1;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      ss_meta_q   <= ss_meta_d;
      ss_sync_q   <= ss_sync_d;
      mosi_meta_q <= mosi_meta_d;
      mosi_sync_q <= mosi_sync_d;
    end
  end

  assign ss_n_s = ss_sync_q;
  assign mosi_s = mosi_sync_q;
`else
  assign ss_n_s = SS_n;
  assign mosi_s = MOSI;
`endif

  // --------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------
  state_e               state_q,      state_d;
  rd_phase_e            rd_phase_q,   rd_phase_d;
  logic [CNT_W-1:0]     cnt_q,        cnt_d;
  logic [FW-2:0]        shift_q,      shift_d;       // first FW-1 frame bits
  logic                 frame_done_q, frame_done_d;
  logic [FW-1:0]        rx_data_q,    rx_data_d;
  logic                 rx_valid_q,   rx_valid_d;
  logic                 addr_rcvd_q,  addr_rcvd_d;
  logic [ADDR_SIZE-1:0] tx_shift_q,   tx_shift_d;
  logic [TXC_W-1:0]     tx_cnt_q,     tx_cnt_d;
  logic                 miso_q,       miso_d;

  logic                 frame_last;

  // State register (FSM plus datapath flops).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rd_phase_q   <= RD_HOLD;
      cnt_q        <= '0;
      shift_q      <= '0;
      frame_done_q <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      addr_rcvd_q  <= 1'b0;
      tx_shift_q   <= '0;
      tx_cnt_q     <= '0;
      miso_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_phase_q   <= rd_phase_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      frame_done_q <= frame_done_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      addr_rcvd_q  <= addr_rcvd_d;
      tx_shift_q   <= tx_shift_d;
      tx_cnt_q     <= tx_cnt_d;
      miso_q       <= miso_d;
    end
  end

  // Next-state logic. SS_n high overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!ss_n_s) state_d = CHK_CMD;
      end
      CHK_CMD: begin
        // Only the command bit picks the transaction type; the opcode
        // bits inside the frame are forwarded to the RAM unchecked.
        if (mosi_s) state_d = addr_rcvd_q ? READ_DATA : READ_ADD;
        else        state_d = WRITE;
      end
      default: state_d = state_q;
    endcase
    if (ss_n_s) state_d = IDLE;
  end

  // Output / datapath logic.
  always_comb begin
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    frame_done_d = frame_done_q;
    rd_phase_d   = rd_phase_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    addr_rcvd_d  = addr_rcvd_q;
    tx_shift_d   = tx_shift_q;
    tx_cnt_d     = tx_cnt_q;
    miso_d       = 1'b0;
    frame_last   = (cnt_q == CNT_W'(FW - 1));

    if (ss_n_s || (state_q == IDLE) || (state_q == CHK_CMD)) begin
      // Deselected or not yet in a data state: rearm the frame logic.
      // addr_rcvd deliberately survives an abort.
      cnt_d        = '0;
      frame_done_d = 1'b0;
      rd_phase_d   = RD_HOLD;
      tx_cnt_d     = '0;
    end else if (!frame_done_q) begin
      shift_d = {shift_q[FW-3:0], mosi_s};
      cnt_d   = cnt_q + CNT_W'(1);
      if (frame_last) begin
        rx_data_d    = {shift_q, mosi_s};
        rx_valid_d   = 1'b1;
        frame_done_d = 1'b1;
        cnt_d        = '0;
        if (state_q == READ_ADD) addr_rcvd_d = 1'b1;
      end
    end else if (state_q == READ_DATA) begin
      case (rd_phase_q)
        RD_HOLD: begin
          rd_phase_d = RD_WAIT;
        end
        RD_WAIT: begin
          if (tx_valid) begin
            miso_d     = tx_data[ADDR_SIZE-1];
            tx_shift_d = tx_data << 1;
            tx_cnt_d   = TXC_W'(1);
            rd_phase_d = RD_SHIFT;
          end
        end
        RD_SHIFT: begin
          if (tx_cnt_q == TXC_W'(ADDR_SIZE)) begin
            // Last bit has had its full cycle: read pair complete.
            addr_rcvd_d = 1'b0;
            rd_phase_d  = RD_DONE;
          end else begin
            miso_d     = tx_shift_q[ADDR_SIZE-1];
            tx_shift_d = tx_shift_q << 1;
            tx_cnt_d   = tx_cnt_q + TXC_W'(1);
          end
        end
        default: rd_phase_d = RD_DONE;
      endcase
    end
    // WRITE / READ_ADD after their frame simply hold until SS_n rises.
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed and random transactions against spi_slave with a
//   transaction-level model of frames, read pairing and MISO byte timing.
// Every edge is checked for rx_valid/rx_data/MISO; addr_rcvd after each txn.

module tb_spi_slave;

`ifdef SPI_IN_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int n_total = 0;
  int n_pass  = 0;
  bit m_addr_rcvd = 1'b0;

  spi_slave #(.ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (ss_n),
    .MOSI     (mosi),
    .MISO     (miso),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input string what,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s.%s: observed %0h expected %0h", tag, what, obs, exp);
  endtask

  // One SPI transaction. Edge index j counts from the edge where SS_n is
  // first driven low. abort_k: input edge at which SS_n rises early (-1 =
  // normal end). rst_off: pulse rst_n at read edge et+rst_off (-1 = none).
  task automatic run_txn(input string tag, input bit cmd, input logic [9:0] frame,
                         input logic [7:0] byte_v, input int delay,
                         input int abort_k, input int rst_off);
    bit         rd;
    bit         done_frame;
    bit         exp_rv;
    bit         exp_miso;
    int         et;
    int         ss_from;
    int         a_edge;
    logic [9:0] fsh;
    logic [7:0] bsh;

    rd         = cmd && m_addr_rcvd;
    et         = 13 + LAT + delay;
    ss_from    = (abort_k >= 0) ? abort_k : (rd ? et + 9 : 14);
    a_edge     = ss_from + LAT;     // edge where the DUT sees SS_n high
    done_frame = (ss_from > 11);

    for (int j = 0; j <= a_edge; j++) begin
      ss_n = (j >= ss_from);
      if (j == 1) begin
        mosi = cmd;
      end else if (j >= 2 && j <= 11) begin
        fsh  = frame << (j - 2);
        mosi = fsh[9];
      end else begin
        mosi = 1'($urandom);
      end

      if (rd) begin
        if (j == 12 + LAT) begin
          tx_valid = 1'b1;             // stale level during the rx_valid cycle
          tx_data  = ~byte_v;
        end else if (j == et) begin
          tx_valid = 1'b1;
          tx_data  = byte_v;
        end else if (j < 12 + LAT || j > et) begin
          tx_valid = 1'($urandom);
          tx_data  = 8'($urandom);
        end else begin
          tx_valid = 1'b0;
          tx_data  = 8'($urandom);
        end
      end else begin
        tx_valid = 1'($urandom);
        tx_data  = 8'($urandom);
      end

      rst_n = !(rst_off >= 0 && j == et + rst_off);
      tick();

      if (!rst_n) begin
        chk(tag, "rst_miso",      32'(miso),             32'(0));
        chk(tag, "rst_rx_valid",  32'(rx_valid),         32'(0));
        chk(tag, "rst_addr_rcvd", 32'(dut.addr_rcvd_q),  32'(0));
        m_addr_rcvd = 1'b0;
        rst_n       = 1'b1;
        ss_n        = 1'b1;
        for (int k = 0; k <= LAT; k++) begin
          tick();
          chk(tag, "post_rst_miso", 32'(miso), 32'(0));
        end
        return;
      end

      exp_rv = done_frame && (j == 11 + LAT);
      chk(tag, "rx_valid", 32'(rx_valid), 32'(exp_rv));
      if (exp_rv) chk(tag, "rx_data", 32'(rx_data), 32'(frame));

      exp_miso = 1'b0;
      if (rd && done_frame && j >= et && j < et + 8 && j < a_edge) begin
        bsh      = byte_v << (j - et);
        exp_miso = bsh[7];
      end
      chk(tag, "miso", 32'(miso), 32'(exp_miso));
    end

    if (done_frame) begin
      if (cmd && !m_addr_rcvd)        m_addr_rcvd = 1'b1;
      else if (rd && et + 8 < a_edge) m_addr_rcvd = 1'b0;
    end
    chk(tag, "addr_rcvd", 32'(dut.addr_rcvd_q), 32'(m_addr_rcvd));
  endtask

  initial begin
    int         ab;
    bit         c;
    logic [9:0] f;
    logic [7:0] b;

    rst_n    = 1'b0;
    ss_n     = 1'b1;
    mosi     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) tick();
    chk("reset", "miso",      32'(miso),            32'(0));
    chk("reset", "rx_valid",  32'(rx_valid),        32'(0));
    chk("reset", "rx_data",   32'(rx_data),         32'(0));
    chk("reset", "addr_rcvd", 32'(dut.addr_rcvd_q), 32'(0));
    rst_n = 1'b1;
    repeat (LAT + 1) tick();

    // Write address / write data.
    run_txn("wr_addr", 1'b0, 10'h005, 8'h00, 0, -1, -1);
    run_txn("wr_data", 1'b0, 10'h1AA, 8'h00, 0, -1, -1);

    // Read pair, RAM answers on the first legal edge.
    run_txn("rd_addr", 1'b1, 10'h205, 8'h00, 0, -1, -1);
    run_txn("rd_data", 1'b1, 10'h300, 8'hAA, 0, -1, -1);

    // Abort after 6 frame bits, then after 9 (SS_n high at the last bit).
    run_txn("abort6",  1'b0, 10'h155, 8'h00, 0, 8, -1);
    run_txn("abort9",  1'b0, 10'h3FF, 8'h00, 0, 11, -1);
    run_txn("post_ab", 1'b0, 10'h0C3, 8'h00, 0, -1, -1);

    // Abort a read-data frame with addr_rcvd set, then mid-byte.
    run_txn("rd_addr2", 1'b1, 10'h2F0, 8'h00, 0, -1, -1);
    run_txn("rd_ab6",   1'b1, 10'h3A5, 8'h00, 0, 8, -1);
    run_txn("rd_abmis", 1'b1, 10'h35A, 8'hC3, 1, 13 + 1 + 3, -1);
    run_txn("rd_late",  1'b1, 10'h300, 8'h5E, 3, -1, -1);

    // Reset while MISO carries bit 3, then a read command must re-enter READ_ADD.
    run_txn("rd_addr3", 1'b1, 10'h211, 8'h00, 0, -1, -1);
    run_txn("rd_rst",   1'b1, 10'h322, 8'hB6, 2, -1, 5);
    run_txn("rd_addr4", 1'b1, 10'h244, 8'h99, 0, -1, -1);
    run_txn("rd_data4", 1'b1, 10'h344, 8'h81, 0, -1, -1);

    // Random traffic.
    for (int i = 0; i < 30; i++) begin
      c  = 1'($urandom);
      f  = 10'($urandom);
      b  = 8'($urandom);
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, 11)) : -1;
      run_txn("rand", c, f, b, int'($urandom_range(0, 4)), ab, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

- Serial front end of the SPI RAM subsystem; sits directly upstream of the RAM and also carries its read data back out.
- Deserialises MOSI frames into 10-bit RAM command words and pulses `rx_valid` for each complete frame.
- On a read-data transaction, waits for the RAM's `tx_valid`, then serialises the returned byte onto MISO.
- All sampling is on `clk`; no separate SCK domain.

## Interface
Parameters:
- `ADDR_SIZE`, 8: RAM address/data width; frame width is `ADDR_SIZE+2`.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low (already decided).
- `SS_n`  in  1  slave select, active-low; high aborts or ends a transaction.
- `MOSI`  in  1  serial data in, MSB first.
- `MISO`  out  1  serial data out, MSB first; 0 when not transmitting.
- `rx_data`  out  ADDR_SIZE+2  frame to RAM: [9:8] opcode, [7:0] address/data.
- `rx_valid`  out  1  one-cycle strobe; `rx_data` is valid while it is high.
- `tx_data`  in  ADDR_SIZE  read byte from RAM.
- `tx_valid`  in  1  RAM read data valid.

## Operation
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- Internal flag `addr_rcvd` (reset 0).
- Transitions:
  - IDLE → CHK_CMD when `SS_n`=0 is sampled.
  - CHK_CMD samples the command bit on MOSI:
    - 0 → WRITE.
    - 1 with `addr_rcvd`=0 → READ_ADD.
    - 1 with `addr_rcvd`=1 → READ_DATA.
  - Any state → IDLE whenever `SS_n`=1 is sampled. This has priority over all other actions.
- WRITE / READ_ADD / READ_DATA:
  - Shift MOSI into a 10-bit register each cycle, counting 0..9.
  - On the 10th bit, load `rx_data` with {shift[8:0], MOSI} and assert `rx_valid` for exactly one cycle.
  - Opcode bits are passed through unchecked; the command bit alone selects the state.
- READ_ADD: on frame completion set `addr_rcvd`=1, then ignore MOSI until `SS_n`=1.
- WRITE: after frame completion, ignore MOSI until `SS_n`=1.
- READ_DATA:
  - After `rx_valid`, wait for `tx_valid`=1. Sampling starts from the second cycle after the `rx_valid` cycle, so a stale level is not taken.
  - Latch `tx_data` when `tx_valid` is sampled high.
  - Shift the byte out on MISO over 8 cycles, MSB first.
  - Clear `addr_rcvd` after the last bit; MISO returns to 0.
  - Further bits in the same transaction are ignored.
- Abort (`SS_n`=1 before frame completion):
  - No `rx_valid`; `addr_rcvd` unchanged; MISO forced to 0.
  - A read-data abort after `rx_valid` but before the byte finishes leaves `addr_rcvd`=1.

## Timing
- Reset values: state IDLE, `MISO`=0, `rx_valid`=0, `rx_data`=0, `addr_rcvd`=0, bit counter 0.
- Reset applied mid-transaction clears everything on that same edge.
- E0: edge sampling `SS_n`=0.
- E1: command bit sampled.
- E2..E11: frame bits 9..0 sampled.
- `rx_data`/`rx_valid` are registered at E11; `rx_valid` is high E11→E12 only.
- Read latency: `tx_valid` sampled high at edge Et (Et ≥ E13). MISO carries bit 7 from Et to Et+1, ..., bit 0 from Et+7 to Et+8, then 0.
- `SS_n`=1 sampled at E11 discards the frame; there is no `rx_valid`.
- Back-to-back transactions: `SS_n` high for one cycle is sufficient; the next E0 may be the following edge.

## Configuration
- `SPI_IN_SYNC_EN` defined:
  - `SS_n` and `MOSI` each pass through a 2-flop synchroniser before the FSM.
  - All input-referenced edges above shift by +2 cycles. MISO/`rx_valid` timing relative to the synchronised inputs is unchanged.
  - Synchroniser flops reset to `SS_n`=1, `MOSI`=0.
- `SPI_IN_SYNC_EN` undefined: inputs are used directly; timing exactly as stated.

## Test plan
- Write address: `SS_n` low, cmd 0, frame 00_0000_0101 → one `rx_valid`, `rx_data`=0x005; MISO stays 0.
- Write data: cmd 0, frame 01_1010_1010 → `rx_data`=0x1AA, single-cycle `rx_valid`.
- Read pair:
  - cmd 1, frame 10_0000_0101 → `rx_data`=0x205, `addr_rcvd`=1.
  - Then cmd 1, frame 11_0000_0000 → `rx_data`=0x300.
  - RAM returns `tx_data`=0xAA with `tx_valid` → MISO emits 1,0,1,0,1,0,1,0 on consecutive cycles; `addr_rcvd`=0.
- Abort: `SS_n` raised after 6 frame bits → no `rx_valid`, state IDLE next cycle, `addr_rcvd` unchanged; the next full frame decodes correctly.
- Reset mid-read: `rst_n`=0 during MISO bit 3 → next cycle MISO=0, `rx_valid`=0, `addr_rcvd`=0; the next cmd 1 enters READ_ADD.
- With `SPI_IN_SYNC_EN`: repeat the write-address case → `rx_valid` appears 2 cycles later than without the macro; same `rx_data`.
